// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch and load/store onto one RAM port
// with configurable read latency, plus a small memory-mapped I/O window.
module mem_responder #(
  parameter int WIDTH = 16,
  parameter int MEM_LATENCY = 1,
  parameter logic [WIDTH-1:0] IO_BASE = WIDTH'(16'hFF00)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] pc_addr,
  output logic             fetch_done,
  output logic [WIDTH-1:0] instr,
  input  logic             loading,
  input  logic             storing,
  input  logic             write_to_memory,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             data_done,
  output logic [WIDTH-1:0] load_data,
  output logic             busy,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] io_switches,
  output logic [WIDTH-1:0] io_leds
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);
  localparam logic [WIDTH-1:0] OFF_LED = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_SW  = WIDTH'(1);
  localparam logic [WIDTH-1:0] OFF_CNT = WIDTH'(2);

  state_t state, state_nxt;

  logic             srv_data;
  logic [1:0]       lat_cnt;
  logic [WIDTH-1:0] cycle_cnt;
  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;

  logic             ld_req;
  logic             st_req;
  logic             fe_req;
  logic             any_req;
  logic             data_sel;
  logic             req_io;
  logic             lat_last;
  logic             clr_cnt;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] io_off;
  logic [WIDTH-1:0] io_rdata;

  // A load masks a simultaneous store; fetch only wins an otherwise idle data port.
  always_comb begin
    ld_req   = loading;
    st_req   = storing && write_to_memory && !loading;
    fe_req   = fetch_req && !loading && !st_req;
    any_req  = ld_req || st_req || fe_req;
    data_sel = ld_req || st_req;
    req_addr = data_sel ? data_addr : pc_addr;
    req_io   = req_addr >= IO_BASE;
    io_off   = req_addr - IO_BASE;
    lat_last = lat_cnt == LAT_LAST;
    clr_cnt  = (state == IDLE) && st_req && req_io
               && (io_off == OFF_CNT);
    io_rdata = '0;
    unique case (1'b1)
      io_off == OFF_LED: io_rdata = io_leds;
      io_off == OFF_SW:  io_rdata = sw_sync;
      io_off == OFF_CNT: io_rdata = cycle_cnt;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (req_io)      state_nxt = RESP;
          else if (st_req) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      READ:    if (lat_last) state_nxt = RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srv_data  <= 1'b0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      instr     <= '0;
      load_data <= '0;
      io_leds   <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            srv_data <= data_sel;
            lat_cnt  <= '0;
            if (!req_io) begin
              mem_addr <= req_addr;
              if (st_req) begin
                mem_wdata <= store_data;
                mem_we    <= 1'b1;
              end
            end else if (st_req) begin
              if (io_off == OFF_LED) io_leds <= store_data;
            end else if (ld_req) begin
              load_data <= io_rdata;
            end else begin
              instr <= io_rdata;
            end
          end
        end
        READ: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_last) begin
            if (srv_data) load_data <= mem_rdata;
            else          instr     <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running counter; a clearing store takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      cycle_cnt <= clr_cnt ? '0 : cycle_cnt + WIDTH'(1);
      sw_meta   <= io_switches;
      sw_sync   <= sw_meta;
    end
  end

  assign busy       = state != IDLE;
  assign fetch_done = (state == RESP) && !srv_data;
  assign data_done  = (state == RESP) && srv_data;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic,
// checked each cycle against a transaction-level model.
module tb_mem_responder;

  localparam int W = 16;
  localparam int L = 2;
  localparam logic [15:0] IOB = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] pc_addr;
  logic        fetch_done;
  logic [15:0] instr;
  logic        loading;
  logic        storing;
  logic        write_to_memory;
  logic [15:0] data_addr;
  logic [15:0] store_data;
  logic        data_done;
  logic [15:0] load_data;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] io_switches;
  logic [15:0] io_leds;

  mem_responder #(.WIDTH(W), .MEM_LATENCY(L), .IO_BASE(IOB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .pc_addr(pc_addr),
    .fetch_done(fetch_done), .instr(instr),
    .loading(loading), .storing(storing),
    .write_to_memory(write_to_memory),
    .data_addr(data_addr), .store_data(store_data),
    .data_done(data_done), .load_data(load_data),
    .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .io_switches(io_switches),
    .io_leds(io_leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ram_init(int i);
    return 16'(i * 257) ^ 16'h3C3C;
  endfunction

  // RAM environment: address register is mem_addr, plus L-1 output stages.
  logic [15:0] ram [256];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    rd_q <= ram[mem_addr[7:0]];
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = rd_q;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, outcome scheduled by latency.
  logic [15:0] mram [256];
  bit          m_valid = 0;
  bit          prev_rst = 0;
  int          m_free, m_done, m_we, cbase;
  bit          p_data, p_read, p_led;
  logic [15:0] p_val, p_addr;
  logic [15:0] m_instr, m_load, m_leds;
  logic [15:0] swh [4];
  bit          rsth [4];
  bit          s_ld, s_st, s_fe;
  logic [15:0] s_a;

  function automatic logic [15:0] sync_val(int c);
    if (rsth[(c-1)&3] || rsth[(c-2)&3]) return 16'h0;
    return swh[(c-2)&3];
  endfunction

  always @(negedge clk) begin
    rsth[cyc&3] = reset;
    swh[cyc&3] = io_switches;
    if (prev_rst) begin
      m_valid = 1; m_free = cyc; m_done = -1; m_we = -1;
      m_instr = 0; m_load = 0; m_leds = 0; cbase = cyc;
    end
    if (m_valid) begin
      if (cyc == m_done && p_read) begin
        if (p_data) m_load = p_val;
        else        m_instr = p_val;
      end
      if (cyc == m_done && p_led) m_leds = p_val;
      chk("busy", 16'(busy), 16'(cyc < m_free));
      chk("fetch_done", 16'(fetch_done),
          16'(cyc == m_done && !p_data));
      chk("data_done", 16'(data_done),
          16'(cyc == m_done && p_data));
      chk("mem_we", 16'(mem_we), 16'(cyc == m_we));
      chk("instr", instr, m_instr);
      chk("load_data", load_data, m_load);
      chk("io_leds", io_leds, m_leds);
      if (cyc == m_we) begin
        chk("mem_addr", mem_addr, p_addr);
        chk("mem_wdata", mem_wdata, p_val);
        mram[p_addr[7:0]] = p_val;
      end
      if (!reset && cyc >= m_free) begin
        s_ld = loading;
        s_st = storing && write_to_memory && !loading;
        s_fe = fetch_req && !s_ld && !s_st;
        if (s_ld || s_st || s_fe) begin
          p_data = s_ld || s_st;
          s_a = p_data ? data_addr : pc_addr;
          p_addr = s_a; p_read = 0; p_led = 0;
          if (s_a >= IOB) begin
            m_done = cyc + 1;
            if (s_st) begin
              if (s_a == IOB) begin
                p_led = 1; p_val = store_data;
              end else if (s_a == IOB + 16'd2) begin
                cbase = cyc + 1;
              end
            end else begin
              p_read = 1;
              if (s_a == IOB)              p_val = m_leds;
              else if (s_a == IOB + 16'd1) p_val = sync_val(cyc);
              else if (s_a == IOB + 16'd2) p_val = 16'(cyc - cbase);
              else                         p_val = 16'h0;
            end
          end else if (s_st) begin
            m_we = cyc + 1; m_done = cyc + 2; p_val = store_data;
          end else begin
            p_read = 1; p_val = mram[s_a[7:0]]; m_done = cyc + 1 + L;
          end
          m_free = m_done + 1;
        end
      end
    end
    prev_rst = reset;
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drop_data();
    loading = 0; storing = 0; write_to_memory = 0;
  endtask

  task automatic set_data(bit st, logic [15:0] a, logic [15:0] d);
    if (st) begin storing = 1; write_to_memory = 1; end
    else loading = 1;
    data_addr = a; store_data = d;
  endtask

  // Holds requests until their done pulse; latencies relative to raise cycle.
  task automatic run(input bit wd, input bit wf, output int ld, output int lf);
    int n;
    n = 0; ld = -1; lf = -1;
    while (((wd && ld < 0) || (wf && lf < 0)) && n < 40) begin
      @(negedge clk);
      n++;
      if (data_done && ld < 0) ld = n - 1;
      if (fetch_done && lf < 0) lf = n - 1;
      @(posedge clk); #1;
      if (ld >= 0) drop_data();
      if (lf >= 0) fetch_req = 0;
    end
    if ((wd && ld < 0) || (wf && lf < 0)) begin
      checks++; fails++;
      $display("FAIL timeout cycle=%0d got=no_done expected=done", cyc);
      drop_data(); fetch_req = 0;
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 16'($urandom_range(0, 255));
    if (k < 9) return IOB + 16'($urandom_range(0, 3));
    return 16'hFF80;
  endfunction

  int ld, lf, k;

  initial begin
    reset = 1; fetch_req = 0; pc_addr = 0; loading = 0;
    storing = 0; write_to_memory = 0; data_addr = 0;
    store_data = 0; io_switches = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] <= ram_init(i);
      mram[i] = ram_init(i);
    end
    ram[8'h10] <= 16'hA5C3;
    mram[8'h10] = 16'hA5C3;
    repeat (4) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_instr", instr, 16'h0);
    chk("rst_load", load_data, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_we", 16'(mem_we), 16'h0);
    @(posedge clk); #1;

    fetch_req = 1; pc_addr = 16'h0010;
    run(0, 1, ld, lf);
    chk("fetch_lat", 16'(lf), 16'd3);
    chk("fetch_instr", instr, 16'hA5C3);

    set_data(0, 16'h0020, 16'h0);
    fetch_req = 1; pc_addr = 16'h0011;
    run(1, 1, ld, lf);
    chk("dual_load_lat", 16'(ld), 16'd3);
    chk("dual_fetch_lat", 16'(lf), 16'd7);
    chk("dual_load_val", load_data, ram_init(32));

    set_data(1, 16'h0030, 16'h1234);
    run(1, 0, ld, lf);
    chk("store_lat", 16'(ld), 16'd2);
    set_data(0, 16'h0030, 16'h0);
    run(1, 0, ld, lf);
    chk("reload", load_data, 16'h1234);

    set_data(1, IOB, 16'h00FF);
    run(1, 0, ld, lf);
    chk("io_store_lat", 16'(ld), 16'd1);
    chk("io_leds", io_leds, 16'h00FF);
    io_switches = 16'h0005;
    idle(3);
    set_data(0, IOB + 16'd1, 16'h0);
    run(1, 0, ld, lf);
    chk("switches", load_data, 16'h0005);

    set_data(1, IOB + 16'd2, 16'hBEEF);
    run(1, 0, ld, lf);
    set_data(0, IOB + 16'd2, 16'h0);
    run(1, 0, ld, lf);
    chk("cnt_clear", load_data, 16'h0001);
    idle(65536);
    set_data(0, IOB + 16'd2, 16'h0);
    run(1, 0, ld, lf);
    chk("cnt_wrap", load_data, 16'h0003);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) io_switches = 16'($urandom);
      idle($urandom_range(0, 2));
      k = $urandom_range(0, 9);
      if (k < 2) begin
        set_data(0, rnd_addr(), 16'h0);
        fetch_req = 1; pc_addr = rnd_addr();
        run(1, 1, ld, lf);
      end else if (k < 4) begin
        if ($urandom_range(0, 1) == 1) storing = 1;
        fetch_req = 1; pc_addr = rnd_addr();
        run(0, 1, ld, lf);
        storing = 0;
      end else if (k < 7) begin
        set_data(0, rnd_addr(), 16'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          storing = 1; write_to_memory = 1;
        end
        run(1, 0, ld, lf);
      end else begin
        set_data(1, rnd_addr(), 16'($urandom));
        run(1, 0, ld, lf);
      end
    end

    set_data(0, 16'h0040, 16'h0);
    @(posedge clk); #1;
    reset = 1;
    drop_data();
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_done", 16'(data_done), 16'h0);
    chk("midrst_load", load_data, 16'h0);
    chk("midrst_we", 16'(mem_we), 16'h0);
    @(posedge clk); #1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
